// File: rtl/cmp_pkg.sv
// Shared constants for the sequenced nibble comparator: FSM encoding and nibble width.
package cmp_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Handshake and operand/result bundle between the requesting control logic (master)
// and the sequenced comparator controller (slave).
interface cmp_seq_ctrl_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             ahigher;
  logic             alower;
  logic             asame;

  modport master (
    output start, a, b,
    input  busy, done, ahigher, alower, asame
  );

  modport slave (
    input  start, a, b,
    output busy, done, ahigher, alower, asame
  );

endinterface

// File: rtl/cmp_nibble.sv
// Purely combinational 4-bit unsigned magnitude compare; exactly one output is high.
module cmp_nibble
  import cmp_pkg::*;
(
  input  logic [NIB_W-1:0] a_nib,
  input  logic [NIB_W-1:0] b_nib,
  output logic             higher,
  output logic             lower,
  output logic             same
);

  assign higher = (a_nib >  b_nib);
  assign lower  = (a_nib <  b_nib);
  assign same   = (a_nib == b_nib);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Sequenced WIDTH-bit magnitude comparator: walks the latched operands MSB nibble first
// through one shared cmp_nibble. Define CMP_EARLY_EXIT_EN to stop at the first unequal nibble.
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  cmp_seq_ctrl_if.slave  bus
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hi_q, hi_d;
  logic             lo_q, lo_d;
  logic             same_q, same_d;

`ifndef CMP_EARLY_EXIT_EN
  // Sticky verdict of the first unequal nibble; lower nibbles may not override it.
  logic             decided_q, decided_d;
  logic             vhi_q, vhi_d;
  logic             vlo_q, vlo_d;
  logic             fin_hi, fin_lo, fin_decided;
`endif

  logic [NIB_W-1:0] a_nibs [NIBBLES];
  logic [NIB_W-1:0] b_nibs [NIBBLES];
  logic [NIB_W-1:0] a_sel, b_sel;
  logic             nib_hi, nib_lo, nib_same;

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib_split
    assign a_nibs[gi] = a_q[gi*NIB_W +: NIB_W];
    assign b_nibs[gi] = b_q[gi*NIB_W +: NIB_W];
  end

  assign a_sel = a_nibs[idx_q];
  assign b_sel = b_nibs[idx_q];

  cmp_nibble u_cmp_nibble (
    .a_nib  (a_sel),
    .b_nib  (b_sel),
    .higher (nib_hi),
    .lower  (nib_lo),
    .same   (nib_same)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    same_d  = same_q;
    done_d  = 1'b0;
`ifndef CMP_EARLY_EXIT_EN
    decided_d   = decided_q;
    vhi_d       = vhi_q;
    vlo_d       = vlo_q;
    fin_decided = decided_q | ~nib_same;
    fin_hi      = decided_q ? vhi_q : nib_hi;
    fin_lo      = decided_q ? vlo_q : nib_lo;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = IDX_TOP;
          hi_d    = 1'b0;
          lo_d    = 1'b0;
          same_d  = 1'b0;
`ifndef CMP_EARLY_EXIT_EN
          decided_d = 1'b0;
          vhi_d     = 1'b0;
          vlo_d     = 1'b0;
`endif
          state_d = ST_CMP;
        end
      end

      ST_CMP: begin
`ifdef CMP_EARLY_EXIT_EN
        if (!nib_same || idx_q == '0) begin
          hi_d    = nib_hi;
          lo_d    = nib_lo;
          same_d  = nib_same;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`else
        if (!decided_q && !nib_same) begin
          decided_d = 1'b1;
          vhi_d     = nib_hi;
          vlo_d     = nib_lo;
        end
        if (idx_q == '0) begin
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          same_d  = ~fin_decided;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`endif
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      same_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      same_q  <= same_d;
    end
  end

`ifndef CMP_EARLY_EXIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decided_q <= 1'b0;
      vhi_q     <= 1'b0;
      vlo_q     <= 1'b0;
    end else begin
      decided_q <= decided_d;
      vhi_q     <= vhi_d;
      vlo_q     <= vlo_d;
    end
  end
`endif

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ahigher = hi_q;
  assign bus.alower  = lo_q;
  assign bus.asame   = same_q;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl: directed and random operations against a
// magnitude/latency reference model; honours CMP_EARLY_EXIT_EN like the design.
module tb_cmp_seq_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_seq_ctrl_if #(.WIDTH(W)) bus ();

  cmp_seq_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int errors  = 0;

  // Compare cycles expected: position of the highest differing bit picks the deciding nibble.
  function automatic int exp_latency(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] x;
    int top;
    x   = av ^ bv;
    top = -1;
    for (int i = 0; i < W; i++) if (x[i]) top = i;
`ifdef CMP_EARLY_EXIT_EN
    if (top < 0) return N;
    return N - (top / 4);
`else
    return N;
`endif
  endfunction

  function automatic logic [2:0] exp_flags(input logic [W-1:0] av, input logic [W-1:0] bv);
    return {av > bv, av < bv, av == bv};
  endfunction

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
  endtask

  // Follows one accepted operation from the accepting edge through the idle gap after done.
  task automatic track(input logic [W-1:0] av, input logic [W-1:0] bv, input bit keep,
                       input logic [W-1:0] nav, input logic [W-1:0] nbv, input string tag);
    int         lat;
    int         n;
    logic [2:0] ef;
    logic [2:0] got;
    lat = exp_latency(av, bv);
    ef  = exp_flags(av, bv);
    @(negedge clk);
    bus.start = keep;
    bus.a     = nav;
    bus.b     = nbv;
    got = {bus.ahigher, bus.alower, bus.asame};
    vectors++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || got !== 3'b000) begin
      errors++;
      $display("FAIL %s accept: busy=%b done=%b flags=%b, required busy=1 done=0 flags=000",
               tag, bus.busy, bus.done, got);
    end
    n = 1;
    while (bus.done !== 1'b1 && n <= N + 3) begin
      @(negedge clk);
      if (!keep) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
      n++;
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, N + 3);
      return;
    end
    got = {bus.ahigher, bus.alower, bus.asame};
    vectors++;
    if (n - 1 !== lat || got !== ef || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s result: latency=%0d flags=%b busy=%b, required latency=%0d flags=%b busy=1",
               tag, n - 1, got, bus.busy, lat, ef);
    end
    @(negedge clk);
    got = {bus.ahigher, bus.alower, bus.asame};
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || got !== ef) begin
      errors++;
      $display("FAIL %s gap: done=%b busy=%b flags=%b, required done=0 busy=0 flags=%b",
               tag, bus.done, bus.busy, got, ef);
    end
    $display("op %-10s a=%h b=%h -> hi/lo/eq=%b latency=%0d", tag, av, bv, got, n - 1);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    issue(av, bv);
    track(av, bv, 1'b0, W'($urandom), W'($urandom), tag);
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.ahigher, bus.alower, bus.asame} !== 5'b0) begin
      errors++;
      $display("FAIL reset: busy/done/hi/lo/eq=%b, required 00000",
               {bus.busy, bus.done, bus.ahigher, bus.alower, bus.asame});
    end
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start: busy=%b while rst held with start, required 0", bus.busy);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    $display("op reset     outputs cleared");
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h1234, "equal");
    run_op(16'h9000, 16'h8FFF, "msb");
    run_op(16'h00A3, 16'h00A4, "lsb");
    run_op(16'h0A00, 16'h0B00, "mid");
  endtask

  task automatic test_midop_reset();
    issue(16'h0000, 16'h0001);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.ahigher, bus.alower, bus.asame} !== 5'b0) begin
      errors++;
      $display("FAIL midop_reset: busy/done/hi/lo/eq=%b, required 00000",
               {bus.busy, bus.done, bus.ahigher, bus.alower, bus.asame});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL midop_quiet: cycle %0d done=%b busy=%b, required 0 0", i, bus.done, bus.busy);
      end
    end
    $display("op midreset  outputs cleared, no done");
    run_op(16'h0000, 16'h0001, "post_rst");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av [5];
    logic [W-1:0] bv [5];
    av = '{16'h4321, 16'h0000, 16'hBEEF, 16'h7777, 16'h0F0F};
    bv = '{16'h4320, 16'h0000, 16'hBEFF, 16'h7777, 16'h0F0E};
    issue(av[0], bv[0]);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) track(av[i], bv[i], 1'b1, av[i+1], bv[i+1], "b2b");
      else       track(av[i], bv[i], 1'b0, W'($urandom), W'($urandom), "b2b_last");
    end
  endtask

  task automatic test_boundary();
    logic [2:0] got;
    run_op(16'hFFFF, 16'h0000, "max_min");
    run_op(16'h0000, 16'hFFFF, "min_max");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      got = {bus.ahigher, bus.alower, bus.asame};
      vectors++;
      if (got !== 3'b010 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL hold: cycle %0d flags=%b busy=%b, required flags=010 busy=0", i, got, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av;
    logic [W-1:0] bv;
    int           k;
    for (int i = 0; i < 40; i++) begin
      av = W'($urandom);
      k  = $urandom_range(0, N - 1);
      case ($urandom_range(0, 2))
        0:       bv = av;
        1:       bv = av ^ (W'($urandom_range(1, 15)) << (4 * k));
        default: bv = W'($urandom);
      endcase
      run_op(av, bv, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_midop_reset();
    test_back_to_back();
    test_boundary();
    test_random();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
